// File: rtl/vga_pixel_gen.sv
// VGA test-pattern generator: rebuilds pixel coordinates from blank/sync timing
// and emits 24-bit RGB with the syncs re-timed to the same two-cycle latency.
module vga_pixel_gen #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CHECK_LOG2      = 5,
    parameter int COORD_W         = 10
) (
    input  logic       vga_clk_in,
    input  logic       reset_in,
    input  logic       blank_n_in,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic [1:0] mode_in,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out,
    output logic       blank_n_out,
    output logic       h_sync_out,
    output logic       v_sync_out
);

    localparam logic               SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);
    localparam int                 BAR_W     = H_ACTIVE / 8;
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACTIVE - 1);

    logic [COORD_W-1:0] x_cnt;
    logic [COORD_W-1:0] y_cnt;
    logic [7:0]         frame_cnt;
    logic [1:0]         mode_reg;
    logic               blank_prev;
    logic               vs_prev;
    logic               vs_edge;
    logic               blank_fall;

    logic [COORD_W-1:0] x_p1;
    logic [COORD_W-1:0] y_p1;
    logic [1:0]         mode_p1;
    logic               vld_p1;
    logic               h_sync_p1;
    logic               v_sync_p1;
    logic [23:0]        pix;

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Bar index is clamped to 7 so an over-long line just extends the last bar.
    function automatic logic [23:0] bar_colour(input logic [COORD_W-1:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(x) >= i * BAR_W) idx = 3'(i);
        end
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    assign vs_edge    = (vs_prev == SYNC_IDLE) && (v_sync_in != SYNC_IDLE);
    assign blank_fall = blank_prev && !blank_n_in;

    always_ff @(posedge vga_clk_in) begin
        if (reset_in) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            frame_cnt  <= 8'd0;
            mode_reg   <= 2'd0;
            blank_prev <= 1'b0;
            vs_prev    <= SYNC_IDLE;
        end else begin
            blank_prev <= blank_n_in;
            vs_prev    <= v_sync_in;
            x_cnt      <= blank_n_in ? sat_inc(x_cnt) : '0;
            if (vs_edge) begin
                y_cnt     <= '0;
                frame_cnt <= frame_cnt + 8'd1;
                mode_reg  <= mode_in;
            end else if (blank_fall) begin
                y_cnt <= sat_inc(y_cnt);
            end
        end
    end

    // Stage 1: capture coordinates, mode and timing for the current pixel
    always_ff @(posedge vga_clk_in) begin
        if (reset_in) begin
            x_p1      <= '0;
            y_p1      <= '0;
            mode_p1   <= 2'd0;
            vld_p1    <= 1'b0;
            h_sync_p1 <= SYNC_IDLE;
            v_sync_p1 <= SYNC_IDLE;
        end else begin
            x_p1      <= x_cnt;
            y_p1      <= y_cnt;
            mode_p1   <= mode_reg;
            vld_p1    <= blank_n_in;
            h_sync_p1 <= h_sync_in;
            v_sync_p1 <= v_sync_in;
        end
    end

    always_comb begin
        pix = 24'h000000;
        if (vld_p1) begin
            case (mode_p1)
                2'd0:    pix = bar_colour(x_p1);
                2'd1:    pix = (x_p1[CHECK_LOG2] ^ y_p1[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
                2'd2:    pix = {x_p1[7:0], y_p1[7:0], frame_cnt};
                default: pix = (x_p1 == '0 || x_p1 == X_LAST || y_p1 == '0 || y_p1 == Y_LAST)
                               ? 24'hFFFFFF : 24'h0000FF;
            endcase
        end
    end

    // Stage 2: RGB and delayed timing leave together
    always_ff @(posedge vga_clk_in) begin
        if (reset_in) begin
            {red_out, green_out, blue_out} <= 24'h000000;
            blank_n_out <= 1'b0;
            h_sync_out  <= SYNC_IDLE;
            v_sync_out  <= SYNC_IDLE;
        end else begin
            {red_out, green_out, blue_out} <= pix;
            blank_n_out <= vld_p1;
            h_sync_out  <= h_sync_p1;
            v_sync_out  <= v_sync_p1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: drives compressed 640x480 frame timing and compares
// the delayed outputs with a pattern model driven by the generated coordinates.
module tb_vga_pixel_gen;

    logic       clk        = 1'b0;
    logic       reset_in   = 1'b1;
    logic       blank_n_in = 1'b0;
    logic       h_sync_in  = 1'b1;
    logic       v_sync_in  = 1'b1;
    logic [1:0] mode_in    = 2'd0;
    logic [7:0] red_out;
    logic [7:0] green_out;
    logic [7:0] blue_out;
    logic       blank_n_out;
    logic       h_sync_out;
    logic       v_sync_out;

    vga_pixel_gen dut (
        .vga_clk_in (clk),
        .reset_in   (reset_in),
        .blank_n_in (blank_n_in),
        .h_sync_in  (h_sync_in),
        .v_sync_in  (v_sync_in),
        .mode_in    (mode_in),
        .red_out    (red_out),
        .green_out  (green_out),
        .blue_out   (blue_out),
        .blank_n_out(blank_n_out),
        .h_sync_out (h_sync_out),
        .v_sync_out (v_sync_out)
    );

    always #5 clk = ~clk;

    logic [23:0] obs_rgb [$];
    logic [2:0]  obs_ctl [$];
    logic [23:0] exp_rgb [$];
    logic [2:0]  exp_ctl [$];
    int          px_x [$];
    int          px_y [$];
    int          px_f [$];
    int          model_frame = 0;
    int          model_mode  = 0;
    int          n_checks    = 0;
    int          n_pass      = 0;

    function automatic logic [23:0] pattern(input int md, input int x, input int y, input int f);
        int idx;
        case (md)
            0: begin
                idx = x / (640 / 8);
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: return ((((x / 32) ^ (y / 32)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2: return {8'(x % 256), 8'(y % 256), 8'(f % 256)};
            default: return (x == 0 || x == 639 || y == 0 || y == 479) ? 24'hFFFFFF : 24'h0000FF;
        endcase
    endfunction

    function automatic int find_px(input int f, input int x, input int y);
        for (int i = 0; i < px_x.size(); i++)
            if (px_f[i] == f && px_x[i] == x && px_y[i] == y) return i;
        return -1;
    endfunction

    // One clock: sample outputs, then apply inputs and log what they should produce.
    task automatic step(input logic r, input logic b, input logic h, input logic v,
                        input logic [1:0] m, input int x, input int y, input bit fs);
        @(posedge clk);
        #1;
        obs_rgb.push_back({red_out, green_out, blue_out});
        obs_ctl.push_back({blank_n_out, h_sync_out, v_sync_out});
        reset_in   = r;
        blank_n_in = b;
        h_sync_in  = h;
        v_sync_in  = v;
        mode_in    = m;
        if (r) begin
            model_frame = 0;
            model_mode  = 0;
            exp_rgb.push_back(24'h000000);
            exp_ctl.push_back(3'b011);
        end else begin
            if (fs) begin
                model_frame++;
                model_mode = int'(m);
            end
            exp_rgb.push_back(b ? pattern(model_mode, x, y, model_frame) : 24'h000000);
            exp_ctl.push_back({b, h, v});
        end
        px_x.push_back((b && !r) ? x : -1);
        px_y.push_back(y);
        px_f.push_back(model_frame);
    endtask

    task automatic drive_frame(input bit coincide, input int mode_at_vs, input int hold_line,
                               input int hold_mode, input int long_line);
        int len, n, nvb, vs_start, vs_len;
        logic [1:0] md;
        logic vsv;
        for (int l = 0; l < 480; l++) begin
            if (l == 0 || l == 3 || l == 32 || l == 100 || l == 200 || l == 240 || l == 479)
                len = 640;
            else if ($urandom_range(0, 99) == 0)
                len = int'($urandom_range(5, 100));
            else
                len = int'($urandom_range(1, 4));
            if (l == long_line) len = 660;
            for (int x = 0; x < len; x++) begin
                md = (hold_line >= 0 && l >= hold_line) ? 2'(hold_mode) : 2'($urandom_range(0, 3));
                step(1'b0, 1'b1, 1'b1, 1'b1, md, x, l, 1'b0);
            end
            if (!(l == 479 && coincide)) begin
                md = (hold_line >= 0 && l >= hold_line) ? 2'(hold_mode) : 2'($urandom_range(0, 3));
                n = int'($urandom_range(1, 2));
                for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, md, -1, l, 1'b0);
                n = int'($urandom_range(1, 3));
                for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, md, -1, l, 1'b0);
                n = int'($urandom_range(1, 2));
                for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, md, -1, l, 1'b0);
            end
        end
        nvb      = int'($urandom_range(20, 40));
        vs_start = coincide ? 0 : int'($urandom_range(1, 10));
        vs_len   = int'($urandom_range(2, 6));
        for (int c = 0; c < nvb; c++) begin
            vsv = (c >= vs_start && c < vs_start + vs_len) ? 1'b0 : 1'b1;
            if (c == vs_start) md = 2'(mode_at_vs);
            else if (hold_line >= 0) md = 2'(hold_mode);
            else md = 2'($urandom_range(0, 3));
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), vsv, md, -1, -1, c == vs_start);
        end
    endtask

    task automatic test_reset();
        int bad;
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, -1, -1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, -1, -1, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), -1, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({obs_rgb[k], obs_ctl[k]} !== {24'h000000, 3'b011})
                $display("FAIL reset_cycle%0d got rgb=%h ctl=%b want rgb=000000 ctl=011",
                         k, obs_rgb[k], obs_ctl[k]);
            else n_pass++;
        end
        bad = 0;
        for (int i = 0; i + 2 < obs_ctl.size(); i++)
            if (obs_ctl[i + 2] !== exp_ctl[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL reset_release_delay got %0d misaligned cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_colour_bars();
        int tx[6] = '{0, 79, 80, 400, 639, 650};
        int ty[6] = '{0, 0, 0, 0, 0, 10};
        logic [23:0] tv[6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFF0000, 24'h000000, 24'h000000};
        logic [23:0] got;
        int i, bad;
        drive_frame(1'b0, 1, -1, 0, 10);
        for (int k = 0; k < 6; k++) begin
            i = find_px(0, tx[k], ty[k]);
            got = (i < 0 || i + 2 >= obs_rgb.size()) ? 24'hxxxxxx : obs_rgb[i + 2];
            n_checks++;
            if (got !== tv[k]) $display("FAIL bars(%0d,%0d) got %h want %h", tx[k], ty[k], got, tv[k]);
            else n_pass++;
        end
        bad = 0;
        for (int j = 0; j + 2 < obs_rgb.size(); j++)
            if (px_f[j] == 0 && px_x[j] < 0 && obs_rgb[j + 2] !== 24'h000000) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL bars_blanked got %0d non-black blank cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_checkerboard();
        int tx[4] = '{0, 32, 32, 0};
        int ty[4] = '{0, 0, 32, 32};
        logic [23:0] tv[4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        logic [23:0] got;
        int i;
        drive_frame(1'b1, 2, -1, 0, -1);
        for (int k = 0; k < 4; k++) begin
            i = find_px(1, tx[k], ty[k]);
            got = (i < 0 || i + 2 >= obs_rgb.size()) ? 24'hxxxxxx : obs_rgb[i + 2];
            n_checks++;
            if (got !== tv[k]) $display("FAIL checker(%0d,%0d) got %h want %h", tx[k], ty[k], got, tv[k]);
            else n_pass++;
        end
    endtask

    task automatic test_gradient();
        int tx[2] = '{5, 10};
        int ty[2] = '{3, 479};
        logic [23:0] tv[2] = '{24'h050302, 24'h0ADF02};
        logic [23:0] got;
        int i;
        drive_frame(1'b0, 3, -1, 0, -1);
        for (int k = 0; k < 2; k++) begin
            i = find_px(2, tx[k], ty[k]);
            got = (i < 0 || i + 2 >= obs_rgb.size()) ? 24'hxxxxxx : obs_rgb[i + 2];
            n_checks++;
            if (got !== tv[k]) $display("FAIL gradient(%0d,%0d) got %h want %h", tx[k], ty[k], got, tv[k]);
            else n_pass++;
        end
    endtask

    task automatic test_border();
        int tx[5] = '{0, 639, 320, 320, 320};
        int ty[5] = '{100, 100, 0, 479, 240};
        logic [23:0] tv[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0000FF};
        logic [23:0] got;
        int i;
        drive_frame(1'($urandom_range(0, 1)), 0, -1, 0, -1);
        for (int k = 0; k < 5; k++) begin
            i = find_px(3, tx[k], ty[k]);
            got = (i < 0 || i + 2 >= obs_rgb.size()) ? 24'hxxxxxx : obs_rgb[i + 2];
            n_checks++;
            if (got !== tv[k]) $display("FAIL border(%0d,%0d) got %h want %h", tx[k], ty[k], got, tv[k]);
            else n_pass++;
        end
    endtask

    task automatic test_mode_change();
        int tf[5] = '{4, 4, 4, 5, 5};
        int tx[5] = '{400, 80, 320, 0, 320};
        int ty[5] = '{200, 240, 479, 0, 240};
        logic [23:0] tv[5] = '{24'hFF0000, 24'hFFFF00, 24'hFF00FF, 24'hFFFFFF, 24'h0000FF};
        logic [23:0] got;
        int i;
        drive_frame(1'b0, 3, 200, 3, -1);
        drive_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 0, -1);
        for (int k = 0; k < 5; k++) begin
            i = find_px(tf[k], tx[k], ty[k]);
            got = (i < 0 || i + 2 >= obs_rgb.size()) ? 24'hxxxxxx : obs_rgb[i + 2];
            n_checks++;
            if (got !== tv[k])
                $display("FAIL mode_change f%0d(%0d,%0d) got %h want %h", tf[k], tx[k], ty[k], got, tv[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int bad_rgb, bad_ctl, first;
        drive_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 0, -1);
        bad_rgb = 0;
        bad_ctl = 0;
        first   = -1;
        for (int i = 0; i + 2 < obs_rgb.size(); i++) begin
            if (obs_rgb[i + 2] !== exp_rgb[i]) begin
                bad_rgb++;
                if (first < 0) first = i;
            end
            if (obs_ctl[i + 2] !== exp_ctl[i]) bad_ctl++;
        end
        n_checks++;
        if (bad_rgb != 0)
            $display("FAIL model_rgb got %0d bad pixels (first cycle %0d: %h) want 0 (first expected %h)",
                     bad_rgb, first, obs_rgb[first + 2], exp_rgb[first]);
        else n_pass++;
        n_checks++;
        if (bad_ctl != 0) $display("FAIL model_timing got %0d bad cycles want 0", bad_ctl);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_colour_bars();
        test_checkerboard();
        test_gradient();
        test_border();
        test_mode_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
